// File: rtl/systolic_pkg.sv
// Shared types and timing constants for the 4x4 systolic array scheduler.
// Imported by the scheduler top and its feed-skew sub-module.
package systolic_pkg;

    localparam int N            = 4;
    localparam int DATA_W       = 8;
    localparam int PE_LATENCY   = 1;

    localparam int FEED_CYCLES  = 2 * N - 1;
    localparam int DRAIN_CYCLES = N - 1 + PE_LATENCY;
    localparam int CNT_W        = $clog2(FEED_CYCLES + DRAIN_CYCLES);

    typedef logic [N-1:0][N-1:0][DATA_W-1:0] matrix_t;
    typedef logic [N-1:0][DATA_W-1:0]        vector_t;
    typedef logic [CNT_W-1:0]                cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_feed_skew.sv
// Combinational wavefront skew: row i gets A[i][t-i], column j gets B[t-j][j].
// All feeds are zero whenever the feed phase is not active.
module systolic_feed_skew
    import systolic_pkg::*;
(
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_b,
    input  logic [CNT_W-1:0]                i_t,
    input  logic                            i_active,
    output logic [N-1:0][DATA_W-1:0]        o_rowFeed,
    output logic [N-1:0][DATA_W-1:0]        o_colFeed
);

    always_comb begin
        o_rowFeed = '0;
        o_colFeed = '0;
        if (i_active) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    // Element k of lane i enters on the anti-diagonal t = i + k.
                    if (i_t == cnt_t'(i + k)) begin
                        o_rowFeed[i] = i_a[i][k];
                        o_colFeed[i] = i_b[k][i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_array_scheduler.sv
// Sequencer for the NxN systolic multiplier: accept A/B, clear PEs, feed
// skewed operands, drain the wavefront, then hold C until consumed.
module systolic_array_scheduler
    import systolic_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_arst,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_b,
    input  logic                            i_validInput,
    output logic                            o_readyInput,
    output logic [N-1:0][DATA_W-1:0]        o_rowFeed,
    output logic [N-1:0][DATA_W-1:0]        o_colFeed,
    output logic                            o_peClear,
    output logic                            o_peEnable,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_peResult,
    output logic [N-1:0][N-1:0][DATA_W-1:0] o_c,
    output logic                            o_validResult,
    input  logic                            i_readyResult,
    output logic                            o_busy
);

    state_t  state_q, state_d;
    cnt_t    cnt_q, cnt_d;
    matrix_t a_q, a_d;
    matrix_t b_q, b_d;
    matrix_t c_q, c_d;
    logic    feed_act;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        o_readyInput  = 1'b0;
        o_peClear     = 1'b0;
        o_peEnable    = 1'b0;
        o_validResult = 1'b0;
        feed_act      = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_readyInput = 1'b1;
                cnt_d        = '0;
                if (i_validInput) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                o_peClear = 1'b1;
                cnt_d     = '0;
                state_d   = FEED;
            end
            FEED: begin
                o_peEnable = 1'b1;
                feed_act   = 1'b1;
                if (cnt_q == cnt_t'(FEED_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                o_peEnable = 1'b1;
                // PE accumulators are final during the last drain cycle.
                if (cnt_q == cnt_t'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    c_d     = i_peResult;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_validResult = 1'b1;
                cnt_d         = '0;
                if (i_readyResult) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    systolic_feed_skew u_skew (
        .i_a       (a_q),
        .i_b       (b_q),
        .i_t       (cnt_q),
        .i_active  (feed_act),
        .o_rowFeed (o_rowFeed),
        .o_colFeed (o_colFeed)
    );

    assign o_c    = c_q;
    assign o_busy = (state_q != IDLE);

endmodule
